pipe_hazard_ctrl: RTL

Parametrised pipeline stall/flush controller, the successor to the decode-side stall logic. It produces per-stage register enables and bubble (NOP-insert) strobes for an N-register pipeline. Stall sources are instruction-cache and data-cache blocking, load-use hazards, taken branches with a multi-cycle fetch squash, and multi-cycle EX operations. A saturating stall-cycle performance counter is included. It sits beside decode and drives the IF/ID, ID/EX, EX/MEM, MEM/WB (and any extra) pipeline registers.

---
 rtl/pipe_hazard_ctrl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller.
// Drives per-stage register enables and bubble (NOP-insert) strobes for an
// N-register in-order pipeline (0=IF/ID, 1=ID/EX, 2=EX/MEM, 3=MEM/WB, extra
// back-end registers above that). Hazard sources, highest priority first:
//   D-cache block > MUL_BUSY/FLUSH state > taken branch > load-use > I-cache.
// The response is combinational from the inputs and the registered state.
// State and counters advance on the clock edge.
// Also keeps a saturating count of cycles in which any stall cause is active.
// NUM_STAGES must be at least 4 and MUL_LAT at least 1.

module pipe_hazard_ctrl #(
  parameter int          NUM_STAGES = 4,
  parameter int          REG_W      = 5,
  parameter int          MUL_LAT    = 4,
  parameter int          FLUSH_CYC  = 1,
  parameter int          CNT_W      = 32,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  block_pipe_instr_cache,
  input  logic                  block_pipe_data_cache,
  input  logic [REG_W-1:0]      dec_rega,
  input  logic [REG_W-1:0]      dec_regb,
  input  logic                  dec_uses_regb,
  input  logic                  dec_is_mul,
  input  logic                  alu_mem_r_en,
  input  logic [REG_W-1:0]      alu_regd,
  input  logic                  branch_taken,
  input  logic                  perf_clr,
  output logic [NUM_STAGES-1:0] en_reg,
  output logic [NUM_STAGES-1:0] bubble,
  output logic                  injecting_nop,
  output logic [31:0]           inject_nop,
  output logic [2:0]            stall_cause,
  output logic [CNT_W-1:0]      stall_cycles
);

  // Controller states.
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MUL_BUSY = 2'd1;
  localparam logic [1:0] ST_FLUSH    = 2'd2;

  // Stall cause encoding seen on stall_cause.
  localparam logic [2:0] CAUSE_NONE     = 3'd0;
  localparam logic [2:0] CAUSE_DCACHE   = 3'd1;
  localparam logic [2:0] CAUSE_FLUSH    = 3'd2;
  localparam logic [2:0] CAUSE_MUL      = 3'd3;
  localparam logic [2:0] CAUSE_LOAD_USE = 3'd4;
  localparam logic [2:0] CAUSE_ICACHE   = 3'd5;

  // The mul counter holds at most MUL_LAT-1, the flush counter at most FLUSH_CYC.
  localparam int MUL_W   = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam int FLUSH_W = (FLUSH_CYC > 0) ? $clog2(FLUSH_CYC + 1) : 1;

  localparam logic [MUL_W-1:0]   MUL_INIT   = MUL_W'(MUL_LAT - 1);
  localparam logic [MUL_W-1:0]   MUL_ONE    = MUL_W'(1);
  localparam logic [FLUSH_W-1:0] FLUSH_INIT = FLUSH_W'(FLUSH_CYC);
  localparam logic [FLUSH_W-1:0] FLUSH_ONE  = FLUSH_W'(1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

  logic [1:0]         state_q, state_d;
  logic [MUL_W-1:0]   mul_cnt_q, mul_cnt_d;
  logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;

  logic load_use;
  logic mul_start;

  // Load-use hazard: the load in EX writes a register decode is about to read.
  // Register 0 is hard-wired to zero and never creates a dependency.
  always_comb begin
    load_use = alu_mem_r_en && (alu_regd != '0) &&
               ((alu_regd == dec_rega) ||
                (dec_uses_regb && (alu_regd == dec_regb)));
  end

  // A long-latency op leaves decode only when decode actually advances into
  // EX: nothing freezes, squashes or holds the decode stage this cycle.
  always_comb begin
    mul_start = (state_q == ST_RUN) && dec_is_mul &&
                !block_pipe_data_cache && !branch_taken && !load_use &&
                !block_pipe_instr_cache;
  end

  // Same-cycle hazard response: enables, bubbles and the reported cause.
  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so a
    // path that skips an assignment cannot infer a latch.
    en_reg      = '1;
    bubble      = '0;
    stall_cause = CAUSE_NONE;

    if (reset) begin
      // Pipeline registers stay enabled and nothing is bubbled while held in reset.
      en_reg      = '1;
      bubble      = '0;
      stall_cause = CAUSE_NONE;
    end else if (block_pipe_data_cache) begin
      // The memory stage cannot complete, so the whole pipe freezes in place.
      en_reg      = '0;
      stall_cause = CAUSE_DCACHE;
    end else begin
      case (state_q)
        ST_MUL_BUSY: begin
          // EX is occupied: hold IF/ID and ID/EX, drain a NOP into EX/MEM.
          en_reg[0]   = 1'b0;
          en_reg[1]   = 1'b0;
          bubble[2]   = 1'b1;
          stall_cause = CAUSE_MUL;
        end
        ST_FLUSH: begin
          // Extra fetch squash after a taken branch; lower hazards are masked
          // because the squashed fetch stream is being thrown away anyway.
          bubble[0]   = 1'b1;
          stall_cause = CAUSE_FLUSH;
        end
        default: begin
          if (branch_taken) begin
            // Wrong-path instructions in fetch and decode become NOPs.
            bubble[0]   = 1'b1;
            bubble[1]   = 1'b1;
            stall_cause = CAUSE_FLUSH;
          end else if (load_use) begin
            // Hold decode one cycle and send a NOP to EX behind the load.
            en_reg[0]   = 1'b0;
            bubble[1]   = 1'b1;
            stall_cause = CAUSE_LOAD_USE;
          end else if (block_pipe_instr_cache) begin
            // No valid fetch word: keep IF/ID and send a NOP down to EX.
            en_reg[0]   = 1'b0;
            bubble[1]   = 1'b1;
            stall_cause = CAUSE_ICACHE;
          end
        end
      endcase
    end
  end

  // Next-state logic; a D-cache freeze holds the state and both counters.
  always_comb begin
    state_d     = state_q;
    mul_cnt_d   = mul_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (!block_pipe_data_cache) begin
      case (state_q)
        ST_RUN: begin
          if (branch_taken) begin
            if (FLUSH_CYC > 0) begin
              state_d     = ST_FLUSH;
              flush_cnt_d = FLUSH_INIT;
            end
          end else if (mul_start) begin
            // The op spends its first EX cycle now; MUL_LAT-1 stall cycles follow.
            if (MUL_LAT > 1) begin
              state_d   = ST_MUL_BUSY;
              mul_cnt_d = MUL_INIT;
            end
          end
        end
        ST_MUL_BUSY: begin
          // A taken branch cannot resolve here: EX is holding the mul.
          mul_cnt_d = mul_cnt_q - MUL_ONE;
          if (mul_cnt_q <= MUL_ONE) begin
            state_d = ST_RUN;
          end
        end
        ST_FLUSH: begin
          flush_cnt_d = flush_cnt_q - FLUSH_ONE;
          if (flush_cnt_q <= FLUSH_ONE) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // Controller state and occupancy counters.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) begin
      state_q     <= ST_RUN;
      mul_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mul_cnt_q   <= mul_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Saturating stall-cycle counter; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (perf_clr) begin
      stall_cycles <= '0;
    end else if ((stall_cause != CAUSE_NONE) && (stall_cycles != CNT_MAX)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

  assign injecting_nop = |bubble;
  assign inject_nop    = NOP_INSTR;

endmodule
